// File: rtl/particle_pkg.sv
// rtl/particle_pkg.sv - shared constants, particle struct and state enum for the particle stream reader
package particle_pkg;

   localparam int COORD_W      = 16;
   localparam int PARTICLE_W   = 32;
   localparam int READ_LATENCY = 2;
   localparam int SCREEN_W     = 1280;
   localparam int SCREEN_H     = 720;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } particle_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   function automatic logic on_screen(input particle_t p);
      return (p.x < COORD_W'(SCREEN_W)) && (p.y < COORD_W'(SCREEN_H));
   endfunction

endpackage

// File: rtl/particle_stream_fifo.sv
// rtl/particle_stream_fifo.sv - output skid FIFO holding particle data plus its buffer index
module particle_stream_fifo
   import particle_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int DATA_W  = PARTICLE_W,
   parameter int INDEX_W = 10,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int OCC_W  = PTR_W + 1
) (
   input  logic               clka,
   input  logic               rstb,
   input  logic               push,
   input  logic [DATA_W-1:0]  push_data,
   input  logic [INDEX_W-1:0] push_index,
   input  logic               pop,
   output logic [DATA_W-1:0]  pop_data,
   output logic [INDEX_W-1:0] pop_index,
   output logic [OCC_W-1:0]   occupancy
);

   logic [INDEX_W+DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]          wr_ptr;
   logic [PTR_W-1:0]          rd_ptr;
   logic                      empty;
   logic                      full;
   logic                      push_ok;
   logic                      pop_ok;
   logic [INDEX_W+DATA_W-1:0] head;

   assign empty = (occupancy == '0);
   assign full  = (occupancy == OCC_W'(DEPTH));

   // A pop on empty is honoured only when a push lands in the same cycle (pass-through)
   assign pop_ok  = pop && (!empty || push);
   assign push_ok = push && (!full || pop_ok);

   assign head      = empty ? {push_index, push_data} : mem[rd_ptr];
   assign pop_data  = head[DATA_W-1:0];
   assign pop_index = head[INDEX_W+DATA_W-1:DATA_W];

   always_ff @(posedge clka) begin
      if (push_ok) begin
         mem[wr_ptr] <= {push_index, push_data};
      end
   end

   always_ff @(posedge clka or negedge rstb) begin
      if (!rstb) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         occupancy <= occupancy + OCC_W'(push_ok) - OCC_W'(pop_ok);
      end
   end

endmodule

// File: rtl/particle_stream_reader.sv
// rtl/particle_stream_reader.sv - sweeps the particle buffer into a valid/ready stream; PARTICLE_STREAM_CULL_EN drops off-screen particles
module particle_stream_reader
   import particle_pkg::*;
#(
   parameter int RAM_DEPTH  = 1024,
   parameter int FIFO_DEPTH = 4,
   localparam int ADDR_W    = $clog2(RAM_DEPTH),
   localparam int OCC_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              start_in,
   input  logic [ADDR_W:0]   count_in,
   output logic              busy_out,
   output logic              done_out,
   output logic [ADDR_W-1:0] ram_addr_out,
   output logic              ram_en_out,
   output logic              ram_regce_out,
   input  logic [31:0]       ram_dout_in,
   output logic              valid_out,
   input  logic              ready_in,
   output logic [15:0]       x_out,
   output logic [15:0]       y_out,
   output logic [ADDR_W-1:0] index_out
);

   state_t                    state;
   logic [ADDR_W:0]           count_r;
   logic [ADDR_W-1:0]         addr_r;
   logic [ADDR_W:0]           count_eff;
   logic                      issue;
   logic                      last_issue;
   logic [READ_LATENCY-1:0]   pipe_v;
   logic [ADDR_W-1:0]         pipe_a [READ_LATENCY];
   logic                      keep;
   logic                      push;
   logic                      pop;
   logic [PARTICLE_W-1:0]     fifo_data;
   logic [ADDR_W-1:0]         fifo_index;
   logic [OCC_W-1:0]          fifo_occ;
   particle_t                 head;

   assign count_eff = (count_in > (ADDR_W+1)'(RAM_DEPTH)) ? (ADDR_W+1)'(RAM_DEPTH) : count_in;

   // Reserve FIFO space for every read still in the pipe so the FIFO can never overflow
   assign issue      = (state == ST_STREAM) &&
                       ((int'(fifo_occ) + $countones(pipe_v)) < FIFO_DEPTH);
   assign last_issue = issue && ({1'b0, addr_r} == (count_r - 1'b1));

`ifdef PARTICLE_STREAM_CULL_EN
   assign keep = on_screen(particle_t'(ram_dout_in));
`else
   assign keep = 1'b1;
`endif

   assign push = pipe_v[READ_LATENCY-1] && keep;
   assign pop  = valid_out && ready_in;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pipe_v <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_a[i] <= '0;
         end
      end else begin
         pipe_v[0] <= issue;
         pipe_a[0] <= addr_r;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state    <= ST_IDLE;
         count_r  <= '0;
         addr_r   <= '0;
         busy_out <= 1'b0;
         done_out <= 1'b0;
      end else begin
         done_out <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_in) begin
                  if (count_eff == '0) begin
                     done_out <= 1'b1;
                  end else begin
                     state    <= ST_STREAM;
                     busy_out <= 1'b1;
                     count_r  <= count_eff;
                     addr_r   <= '0;
                  end
               end
            end
            ST_STREAM: begin
               if (last_issue) begin
                  state <= ST_DRAIN;
               end else if (issue) begin
                  addr_r <= addr_r + 1'b1;
               end
            end
            ST_DRAIN: begin
               // Leave as the final beat is popped so done lands right after the last transfer
               if ((pipe_v == '0) &&
                   ((fifo_occ == '0) || ((fifo_occ == OCC_W'(1)) && pop))) begin
                  state    <= ST_IDLE;
                  busy_out <= 1'b0;
                  done_out <= 1'b1;
                  addr_r   <= '0;
               end
            end
            default: begin
               state    <= ST_IDLE;
               busy_out <= 1'b0;
            end
         endcase
      end
   end

   particle_stream_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .DATA_W  (PARTICLE_W),
      .INDEX_W (ADDR_W)
   ) u_fifo (
      .clka       (clk_in),
      .rstb       (rst_n_in),
      .push       (push),
      .push_data  (ram_dout_in),
      .push_index (pipe_a[READ_LATENCY-1]),
      .pop        (pop),
      .pop_data   (fifo_data),
      .pop_index  (fifo_index),
      .occupancy  (fifo_occ)
   );

   assign head          = particle_t'(fifo_data);
   assign valid_out     = (fifo_occ != '0);
   assign x_out         = valid_out ? head.x : '0;
   assign y_out         = valid_out ? head.y : '0;
   assign index_out     = valid_out ? fifo_index : '0;
   assign ram_addr_out  = addr_r;
   assign ram_en_out    = busy_out;
   assign ram_regce_out = busy_out;

endmodule

// File: tb/tb_particle_stream_reader.sv
// tb/tb_particle_stream_reader.sv - directed and randomized bench for particle_stream_reader
module tb_particle_stream_reader;

   localparam int RAM_DEPTH = 1024;
`ifdef PARTICLE_STREAM_CULL_EN
   localparam bit CULL = 1'b1;
`else
   localparam bit CULL = 1'b0;
`endif

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      int          idx;
   } beat_t;

   logic        clk_in;
   logic        rst_n_in;
   logic        start_in;
   logic [10:0] count_in;
   logic        busy_out;
   logic        done_out;
   logic [9:0]  ram_addr_out;
   logic        ram_en_out;
   logic        ram_regce_out;
   logic [31:0] ram_dout_in;
   logic        valid_out;
   logic        ready_in;
   logic [15:0] x_out;
   logic [15:0] y_out;
   logic [9:0]  index_out;

   logic [31:0] mem [RAM_DEPTH];
   logic [31:0] ram_r1;
   int          checks;
   int          failures;

   particle_stream_reader dut (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .start_in      (start_in),
      .count_in      (count_in),
      .busy_out      (busy_out),
      .done_out      (done_out),
      .ram_addr_out  (ram_addr_out),
      .ram_en_out    (ram_en_out),
      .ram_regce_out (ram_regce_out),
      .ram_dout_in   (ram_dout_in),
      .valid_out     (valid_out),
      .ready_in      (ready_in),
      .x_out         (x_out),
      .y_out         (y_out),
      .index_out     (index_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Two-cycle buffer: address register stage then output register stage
   always @(posedge clk_in) begin
      if (!rst_n_in) begin
         ram_r1      <= '0;
         ram_dout_in <= '0;
      end else begin
         if (ram_en_out)    ram_r1      <= mem[ram_addr_out];
         if (ram_regce_out) ram_dout_in <= ram_r1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit keep(input logic [31:0] w);
      return !CULL || ((w[31:16] < 16'd1280) && (w[15:0] < 16'd720));
   endfunction

   // ready_mode: 0 always ready, 1 toggle 1/0, 2 random; timed checks exact beat/done cycles
   task automatic run_sweep(input int count, input int ready_mode, input bit timed);
      beat_t exp_q[$];
      beat_t b;
      int    n_eff, beats, dones, done_cyc, en_seen, last_idx, budget;
      bit    held;
      logic [15:0] hx, hy;
      logic [9:0]  hi;
      n_eff = (count > RAM_DEPTH) ? RAM_DEPTH : count;
      for (int i = 0; i < n_eff; i++) begin
         if (keep(mem[i])) begin
            b.x = mem[i][31:16];
            b.y = mem[i][15:0];
            b.idx = i;
            exp_q.push_back(b);
         end
      end
      beats = 0; dones = 0; done_cyc = -1; en_seen = 0; last_idx = -1; held = 1'b0;
      hx = '0; hy = '0; hi = '0;
      budget = 4 * n_eff + 64;
      @(posedge clk_in); #1;
      start_in = 1'b1;
      count_in = 11'(count);
      for (int cyc = 1; cyc <= budget && dones == 0; cyc++) begin
         @(posedge clk_in); #1;
         start_in = 1'b0;
         if (ram_en_out) en_seen++;
         if (timed && cyc == 1 && n_eff > 0) begin
            chk("first_addr", 32'(ram_addr_out), 32'd0);
            chk("first_en", 32'(ram_en_out), 32'd1);
         end
         if (held) begin
            chk("hold_valid", 32'(valid_out), 32'd1);
            chk("hold_x", 32'(x_out), 32'(hx));
            chk("hold_y", 32'(y_out), 32'(hy));
            chk("hold_index", 32'(index_out), 32'(hi));
         end
         case (ready_mode)
            0:       ready_in = 1'b1;
            1:       ready_in = (cyc % 2) == 1;
            default: ready_in = 1'($urandom_range(0, 1));
         endcase
         held = 1'b0;
         if (valid_out) begin
            if (exp_q.size() == 0) begin
               chk("extra_beat", 32'(valid_out), 32'd0);
            end else if (ready_in) begin
               chk("beat_x", 32'(x_out), 32'(exp_q[0].x));
               chk("beat_y", 32'(y_out), 32'(exp_q[0].y));
               chk("beat_index", 32'(index_out), 32'(exp_q[0].idx));
               if (timed) chk("beat_cycle", 32'(cyc), 32'(4 + beats));
               last_idx = exp_q[0].idx;
               void'(exp_q.pop_front());
               beats++;
            end else begin
               held = 1'b1;
               hx = x_out; hy = y_out; hi = index_out;
            end
         end
         if (done_out) begin
            dones++;
            done_cyc = cyc;
            chk("busy_at_done", 32'(busy_out), 32'd0);
            chk("valid_at_done", 32'(valid_out), 32'd0);
         end
      end
      ready_in = 1'b0;
      chk("done_seen", 32'(dones), 32'd1);
      chk("beats_left", 32'(exp_q.size()), 32'd0);
      if (timed) begin
         chk("done_cycle", 32'(done_cyc), (n_eff == 0) ? 32'd1 : 32'(4 + n_eff));
         if (n_eff > 0) chk("last_index", 32'(last_idx), 32'(n_eff - 1));
      end
      if (n_eff == 0) chk("no_reads", 32'(en_seen), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"},  32'(busy_out),      32'd0);
      chk({tag, "_done"},  32'(done_out),      32'd0);
      chk({tag, "_addr"},  32'(ram_addr_out),  32'd0);
      chk({tag, "_en"},    32'(ram_en_out),    32'd0);
      chk({tag, "_regce"}, 32'(ram_regce_out), 32'd0);
      chk({tag, "_valid"}, 32'(valid_out),     32'd0);
      chk({tag, "_x"},     32'(x_out),         32'd0);
      chk({tag, "_y"},     32'(y_out),         32'd0);
      chk({tag, "_index"}, 32'(index_out),     32'd0);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n_in = 1'b0;
      start_in = 1'b0;
      count_in = '0;
      ready_in = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      check_all_zero("reset");
      rst_n_in = 1'b1;

      for (int i = 0; i < RAM_DEPTH; i++) mem[i] = {16'(i), 16'(i + 100)};
      run_sweep(8, 0, 1'b1);
      run_sweep(16, 1, 1'b0);
      run_sweep(0, 0, 1'b1);

      for (int i = 0; i < RAM_DEPTH; i++)
         mem[i] = {16'($urandom_range(0, 2000)), 16'($urandom_range(0, 1000))};

      @(posedge clk_in); #1;
      start_in = 1'b1;
      count_in = 11'd32;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk_in); #1;
         start_in = 1'b0;
         ready_in = 1'b1;
      end
      rst_n_in = 1'b0;
      #1;
      check_all_zero("midreset");
      repeat (2) @(posedge clk_in);
      #1;
      ready_in = 1'b0;
      rst_n_in = 1'b1;
      run_sweep(32, 0, 1'b0);

      for (int k = 0; k < 4; k++) run_sweep(int'($urandom_range(1, 40)), 2, 1'b0);

      mem[0] = {16'd1300, 16'd5};
      mem[1] = {16'd10, 16'd10};
      mem[2] = {16'd5, 16'd800};
      run_sweep(3, 0, 1'b0);

      for (int i = 0; i < RAM_DEPTH; i++) mem[i] = {16'(i % 1280), 16'(i % 720)};
      run_sweep(2000, 0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/particle_stream_reader.md
PARTICLE_STREAM_READER -- requirements
Module: particle_stream_reader

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 1024, meaning particle buffer entries; ADDR_W = clog2(RAM_DEPTH).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning output skid FIFO entries (power of two, >= 4).
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Ports, as name  direction  width  meaning:
- clk_in  in  1  sole clock.
- rst_n_in  in  1  asynchronous active-low reset.
- start_in  in  1  single-cycle frame-sweep request.
- count_in  in  ADDR_W+1  number of particles to stream; sampled on accepted start.
- busy_out  out  1  sweep in progress.
- done_out  out  1  single-cycle sweep-complete pulse.
- ram_addr_out  out  ADDR_W  buffer read address.
- ram_en_out  out  1  buffer port enable.
- ram_regce_out  out  1  buffer output-register enable.
- ram_dout_in  in  32  buffer read data, valid 2 cycles after the address cycle.
- valid_out  out  1  particle available.
- ready_in  in  1  consumer accepts the particle.
- x_out  out  16  ram_dout_in[31:16].
- y_out  out  16  ram_dout_in[15:0].
- index_out  out  ADDR_W  buffer address of the presented particle.

Function
REQ-005 SHALL implement states IDLE, STREAM and DRAIN.
REQ-006 IDLE->STREAM on start_in; start_in is ignored while busy_out=1.
REQ-007 count_in greater than RAM_DEPTH SHALL be clamped to RAM_DEPTH; count 0 SHALL give done_out the cycle after start with no reads.
REQ-008 In STREAM, a read SHALL issue, addresses ascending from 0, only if fifo_occupancy + in_flight < FIFO_DEPTH; reads issue at most one per cycle.
REQ-009 ram_en_out and ram_regce_out SHALL be 1 whenever busy_out=1, and 0 otherwise.
REQ-010 A 2-stage valid/address-tag pipe SHALL track in-flight reads; a read issued in cycle t is written to the FIFO at the end of cycle t+2.
REQ-011 Latency: start_in in cycle 0 gives the first address in cycle 1 and valid_out in cycle 4.
REQ-012 With ready_in held at 1, throughput SHALL be one particle per cycle with no bubbles after the first.
REQ-013 While valid_out=1 and ready_in=0, x_out, y_out and index_out SHALL hold stable; the FIFO never overflows.
REQ-014 After the last read issues, STREAM->DRAIN; DRAIN->IDLE when in_flight=0 and the FIFO is empty; done_out pulses in that transition cycle.
REQ-015 A simultaneous FIFO push and pop at full or empty SHALL keep occupancy unchanged and the data correct.

Reset
REQ-016 Asserting rst_n_in at any time SHALL force IDLE and clear the FIFO, in-flight tags and address counter.
REQ-017 All outputs SHALL be 0 during reset, including mid-sweep; in-flight read data SHALL be discarded.

Configuration
REQ-018 With PARTICLE_STREAM_CULL_EN defined, returned particles with x >= 1280 or y >= 720 SHALL be dropped before the FIFO; sweep accounting and done_out still count them.
REQ-019 Without PARTICLE_STREAM_CULL_EN, every read particle SHALL be emitted.

Structure
REQ-020 particle_pkg SHALL hold COORD_W=16, PARTICLE_W=32, READ_LATENCY=2, the screen bounds, the particle struct {x,y} and the state enum.
REQ-021 The FIFO SHALL be the sub-module particle_stream_fifo (data+index, push/pop, occupancy).

Verification
REQ-022 count=8, buffer[i]={i,i+100}, ready=1: 8 beats (x=i, y=i+100, index=i) in cycles 4..11, done_out in cycle 12.
REQ-023 count=16, ready toggling 1-0 every cycle: all 16 in order, no duplicates, 0 overflow, addresses stall when full.
REQ-024 count=0: done_out the cycle after start, ram_en_out never 1.
REQ-025 Reset asserted in cycle 6 of a 32-particle sweep: outputs 0 immediately; a new start streams from index 0.
REQ-026 PARTICLE_STREAM_CULL_EN, entries {1300,5},{10,10},{5,800}: only {10,10} emitted, done_out still pulses.
REQ-027 count=2000, RAM_DEPTH=1024: exactly 1024 beats, last index 1023.
